iterative_shift_reg: RTL and testbench

//   Multi-cycle barrel-replacement shift register for the multicycle MIPS datapath.

---
 rtl/iterative_shift_reg.sv | 107 ++++++++++
 tb/tb_iterative_shift_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_reg.sv
// rtl/iterative_shift_reg.sv - multi-cycle one-bit-per-cycle shifter with start/busy/done handshake
module iterative_shift_reg #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   step_d;
    logic [SHAMT_W-1:0] count_q;
    logic [1:0]         op_q;
    logic               busy_q;
    logic               done_q;

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // One-bit step of the latched operation applied to the current contents
    always_comb begin
        step_d = data_q;
        case (op_q)
            OP_SLL:  step_d = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:  step_d = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:  step_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROR:  step_d = {data_q[0], data_q[WIDTH-1:1]};
            default: step_d = data_q;
        endcase
    end

    // Control FSM; busy/done are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            count_q <= '0;
            op_q    <= OP_SLL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        data_q  <= data_in;
                        count_q <= shamt;
                        op_q    <= op;
                        if (shamt != CNT_ZERO) begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    data_q  <= step_d;
                    count_q <= count_q - CNT_ONE;
                    // Last step: leave SHIFT so count stops at zero rather than wrapping
                    if (count_q == CNT_ONE) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Any start seen here is dropped; a new request must arrive in IDLE
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_shift_reg.sv
// tb/tb_iterative_shift_reg.sv - self-checking bench for iterative_shift_reg
module tb_iterative_shift_reg;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fails;

    iterative_shift_reg #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the whole shift computed in one go with plain operators
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                              input logic [4:0] s);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: begin
                dd = {d, d} >> s;
                return dd[31:0];
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE, then verify busy length, single done pulse and result
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s);
        logic [31:0] exp;
        int busy_cnt;
        int cyc;
        int overlap;
        exp = ref_shift(o, d, s);
        @(negedge clk);
        start = 1'b1; op = o; data_in = d; shamt = s;
        @(negedge clk);
        start = 1'b0; data_in = ~d; op = ~o; shamt = ~s;
        busy_cnt = 0; cyc = 0; overlap = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_during_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(s));
        check({tag, "_result"}, {32'd0, data_out}, {32'd0, exp});
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        check({tag, "_result_held"}, {32'd0, data_out}, {32'd0, exp});
    endtask

    initial begin
        int done_pulses;
        logic [31:0] done_val;
        n_checks = 0;
        n_fails  = 0;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; data_in = '0; shamt = '0;
        repeat (3) @(negedge clk);
        check("reset_data", {32'd0, data_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;

        // Reset mid-shift aborts the operation
        @(negedge clk);
        start = 1'b1; op = 2'b00; data_in = 32'h1; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("midshift_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_data", {32'd0, data_out}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        reset_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            check("abort_stays_idle", {62'd0, busy, done}, 64'd0);
        end

        // Directed cases
        run_op("sll4",   2'b00, 32'h0000_0001, 5'd4);
        run_op("sra31",  2'b10, 32'h8000_0000, 5'd31);
        run_op("srl31",  2'b01, 32'h8000_0000, 5'd31);
        run_op("ror4",   2'b11, 32'h0000_00F1, 5'd4);
        run_op("zero",   2'b00, 32'hDEAD_BEEF, 5'd0);
        run_op("ror0",   2'b11, 32'h1234_5678, 5'd0);
        run_op("sll1",   2'b00, 32'hFFFF_FFFF, 5'd1);
        run_op("sra_pos",2'b10, 32'h7000_0000, 5'd31);

        // Randomized requests against the reference
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), $urandom,
                   5'($urandom_range(0, 31)));
        end

        // start held high with inputs churning during SHIFT and DONE
        @(negedge clk);
        start = 1'b1; op = 2'b00; data_in = 32'h1; shamt = 5'd4;
        done_pulses = 0; done_val = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            data_in = $urandom; op = 2'($urandom_range(0, 3)); shamt = 5'($urandom_range(1, 31));
            if (done === 1'b1) begin
                done_pulses++;
                done_val = data_out;
            end
        end
        check("hold_done_pulses", 64'(done_pulses), 64'd1);
        check("hold_first_result", {32'd0, done_val}, 64'h10);
        // Second request presented while in DONE; only the IDLE edge that follows may take it
        op = 2'b01; data_in = 32'hF000_0000; shamt = 5'd3;
        @(negedge clk);
        check("done_start_ignored", {62'd0, busy, done}, 64'd0);
        check("done_start_data", {32'd0, data_out}, 64'h10);
        @(negedge clk);
        start = 1'b0;
        check("second_accepted", {63'd0, busy}, 64'd1);
        begin
            int cyc;
            cyc = 0;
            while (done !== 1'b1 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("second_done", {63'd0, done}, 64'd1);
        check("second_result", {32'd0, data_out}, {32'd0, ref_shift(2'b01, 32'hF000_0000, 5'd3)});
        @(negedge clk);
        check("second_single_pulse", {63'd0, done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
